// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory access per EX/MEM op and registers the MEM/WB word.
// Latency 1 cycle for ALU ops and granted stores, gnt+rvalid for loads; StallM holds upstream meanwhile.

package mem_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] ALUResult;
        logic [31:0] WriteData;
        logic [31:0] PCPlus4;
        logic [31:0] ImmExt;
        logic [1:0]  ResultSrc;
        logic [4:0]  Rd;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic [2:0]  funct3;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] ALUResult;
        logic [31:0] load_data;
        logic [31:0] PCPlus4;
        logic [31:0] ImmExt;
        logic [1:0]  ResultSrc;
        logic [4:0]  Rd;
        logic        RegWrite;
    } memwb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  exmem_t      inputs,
    output memwb_t      outputs,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        misaligned
);

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  ofs;
    logic        is_mem;
    logic        is_store;
    logic        misal;
    logic        mem_ok;
    logic        req_raw;
    logic        stall_raw;
    logic        load_done;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    memwb_t      wb_nxt;

    assign ofs      = inputs.ALUResult[1:0];
    assign is_mem   = inputs.valid & (inputs.MemRead | inputs.MemWrite);
    assign is_store = inputs.MemWrite;

    // Size comes from funct3[1:0]: 00 byte, 01 half, 1x word.
    always_comb begin
        misal = 1'b0;
        if (inputs.funct3[1])
            misal = (ofs != 2'b00);
        else if (inputs.funct3[0])
            misal = ofs[0];
    end

    assign mem_ok = is_mem & ~misal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_ok) begin
                    if (dmem_gnt)
                        state_nxt = is_store ? IDLE : RESP;
                    else
                        state_nxt = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt)
                    state_nxt = is_store ? IDLE : RESP;
            end
            RESP: begin
                if (dmem_rvalid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A store granted in REQ finishes that cycle, so the stall drops with the
    // grant; otherwise upstream would re-present the same store in IDLE.
    always_comb begin
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                req_raw   = mem_ok;
                stall_raw = mem_ok & ~(dmem_gnt & is_store);
            end
            REQ: begin
                req_raw   = 1'b1;
                stall_raw = ~(dmem_gnt & is_store);
            end
            RESP: begin
                stall_raw = ~dmem_rvalid;
                load_done = dmem_rvalid;
            end
            default: begin
                req_raw   = 1'b0;
                stall_raw = 1'b0;
            end
        endcase
    end

    assign dmem_req = req_raw & rst_n;
    assign StallM   = stall_raw & rst_n;

    // Request fields derive only from the held EX/MEM word, so they stay stable in REQ.
    assign dmem_addr = {inputs.ALUResult[31:2], 2'b00};
    assign dmem_we   = is_store;

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = inputs.WriteData;
        if (is_store) begin
            case (inputs.funct3[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << ofs;
                    dmem_wdata = {4{inputs.WriteData[7:0]}};
                end
                2'b01: begin
                    dmem_be    = ofs[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{inputs.WriteData[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = inputs.WriteData;
                end
            endcase
        end
    end

    always_comb begin
        case (ofs)
            2'b00:   sel_byte = dmem_rdata[7:0];
            2'b01:   sel_byte = dmem_rdata[15:8];
            2'b10:   sel_byte = dmem_rdata[23:16];
            default: sel_byte = dmem_rdata[31:24];
        endcase
        sel_half = ofs[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    always_comb begin
        case (inputs.funct3)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_val = {24'd0, sel_byte};
            3'b101:  load_val = {16'd0, sel_half};
            default: load_val = dmem_rdata;
        endcase
    end

    // Stalled cycles and invalid inputs both register an all-zero bubble.
    always_comb begin
        wb_nxt = '0;
        if (!stall_raw && inputs.valid) begin
            wb_nxt.valid     = 1'b1;
            wb_nxt.ALUResult = inputs.ALUResult;
            wb_nxt.load_data = load_done ? load_val : 32'd0;
            wb_nxt.PCPlus4   = inputs.PCPlus4;
            wb_nxt.ImmExt    = inputs.ImmExt;
            wb_nxt.ResultSrc = inputs.ResultSrc;
            wb_nxt.Rd        = inputs.Rd;
            wb_nxt.RegWrite  = inputs.RegWrite & ~(is_mem & misal);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outputs    <= '0;
            misaligned <= 1'b0;
        end else begin
            outputs    <= wb_nxt;
            misaligned <= is_mem & misal;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table driven through a responder, scoreboarded MEM/WB results.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    exmem_t      inputs;
    memwb_t      outputs;
    logic        StallM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        misaligned;

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inputs     (inputs),
        .outputs    (outputs),
        .StallM     (StallM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        rd;
        logic        wr;
        logic        vld;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          gdly;
        logic        exp_req;
        logic        chk_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_stalls;
        logic [31:0] exp_load;
        logic        exp_rw;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 14;
    vec_t   tbl [NVEC];
    memwb_t exp_q [$];
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic vec_t mk(input string nm, input logic [2:0] f3, input logic rd,
                                input logic wr, input logic vld, input logic rw,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input int gdly,
                                input logic ereq, input logic chkw, input logic [3:0] ebe,
                                input logic [31:0] ewd, input int est,
                                input logic [31:0] eld, input logic erw, input logic emis);
        vec_t v;
        v.name = nm; v.f3 = f3; v.rd = rd; v.wr = wr; v.vld = vld; v.rw = rw;
        v.addr = addr; v.wd = wd; v.rdata = rdata; v.gdly = gdly;
        v.exp_req = ereq; v.chk_wdata = chkw; v.exp_be = ebe; v.exp_wdata = ewd;
        v.exp_stalls = est; v.exp_load = eld; v.exp_rw = erw; v.exp_mis = emis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int i);
        inputs           = '0;
        inputs.valid     = v.vld;
        inputs.ALUResult = v.addr;
        inputs.WriteData = v.wd;
        inputs.PCPlus4   = 32'h400 + 32'(4 * i);
        inputs.ImmExt    = 32'(17 * i + 3);
        inputs.ResultSrc = 2'(i % 3);
        inputs.Rd        = 5'(i + 1);
        inputs.RegWrite  = v.rw;
        inputs.MemRead   = v.rd;
        inputs.MemWrite  = v.wr;
        inputs.funct3    = v.f3;
    endtask

    task automatic run_vec(input int i);
        vec_t   v;
        memwb_t e;
        memwb_t got;
        int     stalls;
        bit     granted;
        bit     done;
        v = tbl[i];
        stalls = 0; granted = 0; done = 0;
        @(negedge clk);
        drive(v, i);
        e = '0;
        if (v.vld) begin
            e.valid     = 1'b1;
            e.ALUResult = v.addr;
            e.load_data = v.exp_load;
            e.PCPlus4   = 32'h400 + 32'(4 * i);
            e.ImmExt    = 32'(17 * i + 3);
            e.ResultSrc = 2'(i % 3);
            e.Rd        = 5'(i + 1);
            e.RegWrite  = v.exp_rw;
        end
        exp_q.push_back(e);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            // rvalid is high with junk data whenever no response is due; the DUT must ignore it.
            dmem_gnt    = !granted && (cyc >= v.gdly);
            dmem_rvalid = 1'b1;
            dmem_rdata  = granted ? v.rdata : 32'hBAD0BAD0;
            #1;
            if (cyc == 0) chk({v.name, " req"}, 32'(dmem_req), 32'(v.exp_req));
            if (dmem_req) begin
                chk({v.name, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
                chk({v.name, " be"}, 32'(dmem_be), 32'(v.exp_be));
                chk({v.name, " we"}, 32'(dmem_we), 32'(v.wr));
                if (v.chk_wdata) chk({v.name, " wdata"}, dmem_wdata, v.exp_wdata);
            end
            if (StallM) stalls++;
            else done = 1;
            if (dmem_req && dmem_gnt) granted = 1;
            @(posedge clk);
            #1;
            if (done) begin
                got = outputs;
                e   = exp_q.pop_front();
                chk({v.name, " valid"}, 32'(got.valid), 32'(e.valid));
                chk({v.name, " alu"}, got.ALUResult, e.ALUResult);
                chk({v.name, " load_data"}, got.load_data, e.load_data);
                chk({v.name, " pc4"}, got.PCPlus4, e.PCPlus4);
                chk({v.name, " imm"}, got.ImmExt, e.ImmExt);
                chk({v.name, " rsrc"}, 32'(got.ResultSrc), 32'(e.ResultSrc));
                chk({v.name, " rd"}, 32'(got.Rd), 32'(e.Rd));
                chk({v.name, " regwrite"}, 32'(got.RegWrite), 32'(e.RegWrite));
                chk({v.name, " misaligned"}, 32'(misaligned), 32'(v.exp_mis));
                chk({v.name, " stall_cycles"}, 32'(stalls), 32'(v.exp_stalls));
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: stall never dropped after 20 cycles", v.name);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        tbl[0]  = mk("lw",     3'b010, 1, 0, 1, 1, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0, 4'hF, 32'h0, 1, 32'hDEADBEEF, 1, 0);
        tbl[1]  = mk("lb",     3'b000, 1, 0, 1, 1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, 0, 4'hF, 32'h0, 1, 32'hFFFFFF80, 1, 0);
        tbl[2]  = mk("lbu",    3'b100, 1, 0, 1, 1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, 0, 4'hF, 32'h0, 1, 32'h00000080, 1, 0);
        tbl[3]  = mk("sh_hi",  3'b001, 0, 1, 1, 0, 32'h202, 32'h0000ABCD, 32'h0, 3, 1, 1, 4'hC, 32'hABCDABCD, 3, 32'h0, 0, 0);
        tbl[4]  = mk("lw_mis", 3'b010, 1, 0, 1, 1, 32'h101, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 1);
        tbl[5]  = mk("alu",    3'b000, 0, 0, 1, 1, 32'h12345678, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0);
        tbl[6]  = mk("bubble", 3'b000, 0, 0, 0, 1, 32'h55, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0);
        tbl[7]  = mk("sb",     3'b000, 0, 1, 1, 0, 32'h201, 32'h000000A5, 32'h0, 0, 1, 1, 4'h2, 32'hA5A5A5A5, 0, 32'h0, 0, 0);
        tbl[8]  = mk("lh",     3'b001, 1, 0, 1, 1, 32'h102, 32'h0, 32'h80011234, 1, 1, 0, 4'hF, 32'h0, 2, 32'hFFFF8001, 1, 0);
        tbl[9]  = mk("lhu",    3'b101, 1, 0, 1, 1, 32'h100, 32'h0, 32'h8001F00D, 0, 1, 0, 4'hF, 32'h0, 1, 32'h0000F00D, 1, 0);
        tbl[10] = mk("sw",     3'b010, 0, 1, 1, 0, 32'h300, 32'h11223344, 32'h0, 1, 1, 1, 4'hF, 32'h11223344, 1, 32'h0, 0, 0);
        tbl[11] = mk("sh_mis", 3'b001, 0, 1, 1, 0, 32'h203, 32'h1234, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 1);
        tbl[12] = mk("sh_lo",  3'b001, 0, 1, 1, 0, 32'h200, 32'h0000BEEF, 32'h0, 0, 1, 1, 4'h3, 32'hBEEFBEEF, 0, 32'h0, 0, 0);
        tbl[13] = mk("lb_b0",  3'b000, 1, 0, 1, 1, 32'h200, 32'h0, 32'h0000007F, 2, 1, 0, 4'hF, 32'h0, 3, 32'h0000007F, 1, 0);

        // Reset with a valid load presented: nothing may escape.
        rst_n       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        drive(tbl[0], 0);
        #1;
        chk("rst outputs.valid", 32'(outputs.valid), 32'h0);
        chk("rst outputs.alu", outputs.ALUResult, 32'h0);
        chk("rst misaligned", 32'(misaligned), 32'h0);
        chk("rst StallM", 32'(StallM), 32'h0);
        chk("rst dmem_req", 32'(dmem_req), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Reset dropped while waiting in RESP; later rvalid pulses must be ignored.
        @(negedge clk);
        drive(tbl[0], 0);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("resp stall before reset", 32'(StallM), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst outputs.valid", 32'(outputs.valid), 32'h0);
        chk("midrst outputs.load", outputs.load_data, 32'h0);
        chk("midrst StallM", 32'(StallM), 32'h0);
        chk("midrst dmem_req", 32'(dmem_req), 32'h0);
        inputs.valid = 1'b0;
        dmem_rvalid  = 1'b1;
        dmem_rdata   = 32'h55AA55AA;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst outputs.valid", 32'(outputs.valid), 32'h0);
        chk("postrst outputs.load", outputs.load_data, 32'h0);
        chk("postrst outputs.regwrite", 32'(outputs.RegWrite), 32'h0);
        chk("postrst StallM", 32'(StallM), 32'h0);
        dmem_rvalid = 1'b0;
        // A fresh load must see the IDLE-state timing again.
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
